// File: rtl/capture_ctrl.sv
// Capture RAM write controller: pre-trigger fill, armed wait, post-trigger count, done hold.
// Writes are combinational on each qualified sample strobe; all status comes from registered state.
module capture_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_strt,
    input  logic              cap_abort,
    input  logic              smpl_en,
    input  logic              trig,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              dump_busy,
    input  logic              done_clr,
    output logic              cap_en,
    output logic              we,
    output logic [ADDR_W-1:0] cap_addr,
    output logic [ADDR_W-1:0] trace_end,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_DONE} state_t;
    state_t state;

    logic [ADDR_W:0]   pre_cnt, pre_nxt, fill_tgt, post_nxt;
    logic [ADDR_W-1:0] post_cnt;
    logic              wr;

    // trig_pos = 0 gives a target of DEPTH, hence the extra bit on pre_cnt
    assign fill_tgt = DEPTH - {1'b0, trig_pos};
    assign pre_nxt  = pre_cnt + (ADDR_W+1)'(1);
    assign post_nxt = {1'b0, post_cnt} + (ADDR_W+1)'(1);

    assign wr = smpl_en && !cap_abort &&
                (state == S_FILL || state == S_ARMED || state == S_POST);
    assign cap_en = wr;
    assign we     = wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cap_addr     <= '0;
            trace_end    <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            armed        <= 1'b0;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
        end else if (cap_abort) begin
            state        <= S_IDLE;
            armed        <= 1'b0;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (cap_strt && !dump_busy) begin
                    state    <= S_FILL;
                    cap_addr <= '0;
                    pre_cnt  <= '0;
                    post_cnt <= '0;
                end
                S_FILL: if (smpl_en) begin
                    cap_addr <= cap_addr + ADDR_W'(1);
                    pre_cnt  <= pre_nxt;
                    if (pre_nxt == fill_tgt) begin
                        state <= S_ARMED;
                        armed <= 1'b1;
                    end
                end
                S_ARMED: if (smpl_en) begin
                    cap_addr <= cap_addr + ADDR_W'(1);
                    if (trig) begin
                        armed     <= 1'b0;
                        triggered <= 1'b1;
                        if (trig_pos == '0) begin
                            state        <= S_DONE;
                            trace_end    <= cap_addr;
                            capture_done <= 1'b1;
                        end else begin
                            state    <= S_POST;
                            post_cnt <= '0;
                        end
                    end
                end
                S_POST: if (smpl_en) begin
                    cap_addr <= cap_addr + ADDR_W'(1);
                    post_cnt <= post_nxt[ADDR_W-1:0];
                    if (post_nxt == {1'b0, trig_pos}) begin
                        state        <= S_DONE;
                        trace_end    <= cap_addr;
                        capture_done <= 1'b1;
                    end
                end
                S_DONE: if (done_clr) begin
                    state        <= S_IDLE;
                    triggered    <= 1'b0;
                    capture_done <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with hand-computed expectations (ADDR_W = 9).
module tb_capture_ctrl;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cap_strt, cap_abort, smpl_en, trig, dump_busy, done_clr;
    logic [ADDR_W-1:0] trig_pos;
    logic              cap_en, we, armed, triggered, capture_done;
    logic [ADDR_W-1:0] cap_addr, trace_end;

    int n_chk  = 0;
    int n_fail = 0;

    capture_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .cap_strt(cap_strt), .cap_abort(cap_abort),
        .smpl_en(smpl_en), .trig(trig), .trig_pos(trig_pos), .dump_busy(dump_busy),
        .done_clr(done_clr), .cap_en(cap_en), .we(we), .cap_addr(cap_addr),
        .trace_end(trace_end), .armed(armed), .triggered(triggered),
        .capture_done(capture_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        cap_strt = 1'b1;
        cyc();
        cap_strt = 1'b0;
    endtask

    function automatic logic [31:0] flags();
        return {29'd0, armed, triggered, capture_done};
    endfunction

    initial begin
        int bad;
        int exp_addr;
        rst_n = 1'b0; cap_strt = 0; cap_abort = 0; smpl_en = 0; trig = 0;
        dump_busy = 0; done_clr = 0; trig_pos = '0;
        #12;
        chk("rst_flags", flags(), 0);
        chk("rst_addr", cap_addr, 0);
        chk("rst_trace_end", trace_end, 0);
        chk("rst_we", {cap_en, we}, 0);
        rst_n = 1'b1;
        cyc();

        // start blocked by dump_busy, not queued
        smpl_en = 1; dump_busy = 1; cap_strt = 1;
        cyc();
        cap_strt = 0; dump_busy = 0; #1;
        chk("busy_we", {cap_en, we}, 0);
        cyc();
        chk("busy_noqueue_we", {cap_en, we}, 0);

        // trig_pos=100, trig continuous
        trig_pos = 100; trig = 1;
        start();
        bad = 0;
        for (int i = 0; i < 412; i++) begin
            if (cap_addr != i || we !== 1'b1 || cap_en !== 1'b1 || armed !== 1'b0) bad++;
            cyc();
        end
        chk("tp100_fill_seq", bad, 0);
        chk("tp100_armed", flags(), 3'b100);
        chk("tp100_trig_addr", cap_addr, 412);
        cyc();
        chk("tp100_post_flags", flags(), 3'b010);
        bad = 0;
        for (int j = 0; j < 100; j++) begin
            if (cap_addr != (413 + j) % 512 || we !== 1'b1 || capture_done !== 1'b0) bad++;
            cyc();
        end
        chk("tp100_post_seq", bad, 0);
        chk("tp100_done_flags", flags(), 3'b011);
        chk("tp100_trace_end", trace_end, 0);
        chk("tp100_done_we", we, 0);
        cap_strt = 1; cyc(); cap_strt = 0;
        chk("done_ignores_strt", flags(), 3'b011);
        done_clr = 1; cyc(); done_clr = 0;
        chk("done_clr_flags", flags(), 0);

        // trig_pos=0: full fill, trigger at address 0, no POST
        trig_pos = 0; trig = 1;
        start();
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (cap_addr != i || we !== 1'b1 || armed !== 1'b0) bad++;
            cyc();
        end
        chk("tp0_fill_seq", bad, 0);
        chk("tp0_armed", flags(), 3'b100);
        chk("tp0_trig_addr", cap_addr, 0);
        cyc();
        chk("tp0_done_flags", flags(), 3'b011);
        chk("tp0_trace_end", trace_end, 0);
        done_clr = 1; cyc(); done_clr = 0;

        // trig_pos=256, trig pulses during FILL ignored; delayed trigger
        trig_pos = 256;
        start();
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            trig = (i % 3 == 0);
            #1;
            if (cap_addr != i || we !== 1'b1 || armed !== 1'b0 || triggered !== 1'b0) bad++;
            cyc();
        end
        chk("tp256_fill_seq", bad, 0);
        chk("tp256_armed", flags(), 3'b100);
        trig = 0;
        repeat (3) cyc();
        chk("tp256_hold_armed", flags(), 3'b100);
        chk("tp256_trig_addr", cap_addr, 259);
        trig = 1; cyc(); trig = 0;
        chk("tp256_post_flags", flags(), 3'b010);
        bad = 0;
        for (int j = 0; j < 256; j++) begin
            if (cap_addr != (260 + j) % 512 || capture_done !== 1'b0) bad++;
            cyc();
        end
        chk("tp256_post_seq", bad, 0);
        chk("tp256_done", flags(), 3'b011);
        chk("tp256_trace_end", trace_end, 3);
        done_clr = 1; cyc(); done_clr = 0;

        // abort during POST, with competing inputs asserted
        trig_pos = 100; trig = 1;
        start();
        repeat (413 + 10) cyc();
        chk("abort_pre_flags", flags(), 3'b010);
        cap_abort = 1; cap_strt = 1; done_clr = 1; #1;
        chk("abort_we", {cap_en, we}, 0);
        cyc();
        cap_abort = 0; cap_strt = 0; done_clr = 0; #1;
        chk("abort_flags", flags(), 0);
        chk("abort_trace_end", trace_end, 3);
        chk("abort_addr_hold", cap_addr, 423);
        chk("abort_idle_we", {cap_en, we}, 0);

        // sparse strobes: one advance per strobe
        trig_pos = 256; trig = 0; smpl_en = 0;
        start();
        bad = 0; exp_addr = 0;
        for (int c = 0; c < 40; c++) begin
            smpl_en = (c % 4 == 0);
            #1;
            if (we !== smpl_en) bad++;
            cyc();
            if (smpl_en) exp_addr++;
            if (cap_addr != exp_addr) bad++;
        end
        chk("gap_seq", bad, 0);
        chk("gap_addr", cap_addr, 10);
        cap_abort = 1; cyc(); cap_abort = 0;

        // reset mid-FILL
        trig_pos = 100; smpl_en = 1;
        start();
        repeat (37) cyc();
        chk("rstmid_addr_pre", cap_addr, 37);
        #2; rst_n = 1'b0; #1;
        chk("rstmid_addr", cap_addr, 0);
        chk("rstmid_trace_end", trace_end, 0);
        chk("rstmid_flags", flags(), 0);
        chk("rstmid_we", {cap_en, we}, 0);
        @(negedge clk); rst_n = 1'b1;
        cyc();
        chk("rstrel_we", {cap_en, we}, 0);
        chk("rstrel_addr", cap_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
